sd_spi_init_sequencer: RTL and testbench

- Sequences the SD card SPI-mode power-up and initialisation over the team's byte-level SPI controller (tx byte/valid/ready, rx byte/valid).
- Owns the card chip-select.
- Issues dummy clocks, then CMD0, CMD8, the CMD55/ACMD41 polling loop and CMD58.
- Reports ready/error plus the card capacity class; sits between the camera storage FSM and the SPI byte engine.

---
 rtl/sd_spi_init_sequencer_if.sv | 15 +
 rtl/sd_spi_init_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sd_spi_init_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_init_sequencer_if.sv
// Byte-level SPI engine handshake between the init sequencer and the SPI engine.
//   tx_byte/tx_dv : byte and one-cycle strobe toward the engine
//   tx_ready      : engine idle, may accept a strobe
//   rx_dv/rx_byte : byte clocked back from the card for the last transfer
// master = sequencer side, slave = SPI engine side.
interface sd_spi_init_sequencer_if;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (output tx_byte, tx_dv, input tx_ready, rx_dv, rx_byte);
  modport slave  (input tx_byte, tx_dv, output tx_ready, rx_dv, rx_byte);
endinterface

// File: rtl/sd_spi_init_sequencer.sv
// SD card SPI-mode power-up sequencer: dummy clocks, CMD0, CMD8, CMD55/ACMD41
// polling, CMD58, then reports done/error and the card capacity class.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_start          : one-cycle start pulse (honoured when not busy)
//   o_busy, o_init_done, o_error, o_err_code[2:0], o_sdhc : status
//   o_sd_cs          : card chip-select, active low
//   spi              : byte engine handshake (master side)
module sd_spi_init_sequencer #(
  parameter int DUMMY_BYTES    = 10,
  parameter int RESP_TIMEOUT   = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_error,
  output logic [2:0] o_err_code,
  output logic       o_sdhc,
  output logic       o_sd_cs,
  sd_spi_init_sequencer_if.master spi
);
  localparam int RW = $clog2(ACMD41_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DUMMY, S_CMD_TX, S_R1_WAIT, S_TAIL, S_GAP, S_DONE, S_ERROR
  } state_t;
  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58} cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    r1_q, r1_d;
  logic          ccs_q, ccs_d;       // trailer bit 30
  logic [11:0]   tail12_q, tail12_d; // trailer bits 11:0
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [2:0]    err_q, err_d;
  logic          sdhc_q, sdhc_d;

  logic        sending, fire, rx_done;
  logic [5:0]  c_idx;
  logic [31:0] c_arg;
  logic [7:0]  c_crc, tx_byte;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= C_CMD0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      r1_q     <= 8'hFF;
      ccs_q    <= 1'b0;
      tail12_q <= '0;
      retry_q  <= '0;
      err_q    <= '0;
      sdhc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      r1_q     <= r1_d;
      ccs_q    <= ccs_d;
      tail12_q <= tail12_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
      sdhc_q   <= sdhc_d;
    end
  end

  // Command table
  always_comb begin
    c_idx = 6'd0; c_arg = 32'h0; c_crc = 8'h95;
    unique case (cmd_q)
      C_CMD8:   begin c_idx = 6'd8;  c_arg = 32'h0000_01AA; c_crc = 8'h87; end
      C_CMD55:  begin c_idx = 6'd55; c_crc = 8'h65; end
      C_ACMD41: begin c_idx = 6'd41; c_arg = 32'h4000_0000; c_crc = 8'h77; end
      C_CMD58:  begin c_idx = 6'd58; c_crc = 8'hFD; end
      default:  ;
    endcase
  end

  // Every state that moves a byte holds at most one transfer in flight:
  // a new strobe waits for the rx_dv of the previous one.
  assign sending = (state_q inside {S_DUMMY, S_CMD_TX, S_R1_WAIT, S_TAIL, S_GAP});
  assign fire    = sending && !pend_q && spi.tx_ready;
  assign rx_done = pend_q && spi.rx_dv;

  // tx byte depends only on state/cnt/cmd, which change on rx_done, so it
  // stays stable for the whole transfer.
  always_comb begin
    tx_byte = 8'hFF;
    if (state_q == S_CMD_TX) begin
      case (cnt_q[2:0])
        3'd0:    tx_byte = {2'b01, c_idx};
        3'd1:    tx_byte = c_arg[31:24];
        3'd2:    tx_byte = c_arg[23:16];
        3'd3:    tx_byte = c_arg[15:8];
        3'd4:    tx_byte = c_arg[7:0];
        3'd5:    tx_byte = c_crc;
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  assign retry_inc = (retry_q == RW'(ACMD41_RETRIES)) ? retry_q : retry_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    r1_d     = r1_q;
    ccs_d    = ccs_q;
    tail12_d = tail12_q;
    retry_d  = retry_q;
    err_d    = err_q;
    sdhc_d   = sdhc_q;
    if (fire)    pend_d = 1'b1;
    if (rx_done) pend_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (i_start) begin
        state_d = S_DUMMY;
        cmd_d   = C_CMD0;
        cnt_d   = '0;
        retry_d = '0;
        err_d   = '0;
        sdhc_d  = 1'b0;
      end
      S_DUMMY: if (rx_done) begin
        if (cnt_q == 16'(DUMMY_BYTES - 1)) begin
          state_d = S_CMD_TX; cnt_d = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_CMD_TX: if (rx_done) begin
        if (cnt_q == 16'd5) begin
          state_d = S_R1_WAIT; cnt_d = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_R1_WAIT: if (rx_done) begin
        if (!spi.rx_byte[7]) begin
          r1_d    = spi.rx_byte;
          cnt_d   = '0;
          state_d = (cmd_q == C_CMD8 || cmd_q == C_CMD58) ? S_TAIL : S_GAP;
        end else if (cnt_q == 16'(RESP_TIMEOUT - 1)) begin
          state_d = S_ERROR; err_d = 3'd5;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_TAIL: if (rx_done) begin
        // Only the trailer bits the sequencer acts on are kept.
        case (cnt_q[1:0])
          2'd0:    ccs_d = spi.rx_byte[6];
          2'd2:    tail12_d[11:8] = spi.rx_byte[3:0];
          2'd3:    tail12_d[7:0]  = spi.rx_byte;
          default: ;
        endcase
        if (cnt_q == 16'd3) begin
          state_d = S_GAP; cnt_d = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_GAP: if (rx_done) begin
        state_d = S_CMD_TX;
        unique case (cmd_q)
          C_CMD0:
            if (r1_q == 8'h01) cmd_d = C_CMD8;
            else begin state_d = S_ERROR; err_d = 3'd1; end
          C_CMD8:
            if (r1_q == 8'h01 && tail12_q == 12'h1AA) cmd_d = C_CMD55;
            else begin state_d = S_ERROR; err_d = 3'd2; end
          C_CMD55:
            if (r1_q == 8'h00 || r1_q == 8'h01) cmd_d = C_ACMD41;
            else begin state_d = S_ERROR; err_d = 3'd3; end
          C_ACMD41:
            if (r1_q == 8'h00) cmd_d = C_CMD58;
            else if (r1_q == 8'h01) begin
              retry_d = retry_inc;
              if (retry_inc == RW'(ACMD41_RETRIES)) begin
                state_d = S_ERROR; err_d = 3'd3;
              end else cmd_d = C_CMD55;
            end else begin state_d = S_ERROR; err_d = 3'd3; end
          default:
            if (r1_q == 8'h00) begin state_d = S_DONE; sdhc_d = ccs_q; end
            else begin state_d = S_ERROR; err_d = 3'd4; end
        endcase
      end
      default: ;
    endcase
  end

  assign o_busy      = sending;
  assign o_init_done = (state_q == S_DONE);
  assign o_error     = (state_q == S_ERROR);
  assign o_err_code  = err_q;
  assign o_sdhc      = sdhc_q;
  assign o_sd_cs     = !(state_q inside {S_CMD_TX, S_R1_WAIT, S_TAIL});
  assign spi.tx_dv   = fire;
  assign spi.tx_byte = tx_byte;
endmodule

// File: tb/tb_sd_spi_init_sequencer.sv
module tb_sd_spi_init_sequencer;
  localparam int RETRIES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err, sdhc, cs;
  logic [2:0] code;

  sd_spi_init_sequencer_if spi();

  sd_spi_init_sequencer #(.DUMMY_BYTES(10), .RESP_TIMEOUT(8), .ACMD41_RETRIES(RETRIES)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_busy(busy), .o_init_done(done), .o_error(err), .o_err_code(code),
    .o_sdhc(sdhc), .o_sd_cs(cs), .spi(spi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- card scenario ----------------
  bit          silent;
  logic [31:0] echo, ocr;
  int          busy_n;

  // ---------------- SPI engine + card model ----------------
  bit         eng_busy;
  int         eng_lat;
  logic [7:0] eng_byte, eng_resp, card_reply;
  logic [7:0] cmd_buf[$];
  logic [7:0] resp_q[$];
  int         acmd_cnt;
  int         viol = 0;
  logic [7:0] log_b[$];
  bit         log_cs[$];

  assign spi.tx_ready = !eng_busy;

  task automatic push32(input logic [31:0] v);
    for (int k = 3; k >= 0; k--) resp_q.push_back(v[8*k +: 8]);
  endtask

  task automatic respond(input logic [5:0] idx);
    repeat ($urandom_range(0, 2)) resp_q.push_back(8'hFF);
    case (idx)
      6'd0:  begin acmd_cnt = 0; if (!silent) resp_q.push_back(8'h01); end
      6'd8:  begin resp_q.push_back(8'h01); push32(echo); end
      6'd55: resp_q.push_back(8'h01);
      6'd41: begin acmd_cnt++; resp_q.push_back(acmd_cnt <= busy_n ? 8'h01 : 8'h00); end
      6'd58: begin resp_q.push_back(8'h00); push32(ocr); end
      default: resp_q.push_back(8'h04);
    endcase
  endtask

  always @(posedge clk) begin
    spi.rx_dv <= 1'b0;
    if (rst_n && eng_busy && spi.tx_dv) viol++;
    if (rst_n && eng_busy && spi.tx_byte !== eng_byte) viol++;
    if (eng_busy) begin
      if (eng_lat == 0) begin
        spi.rx_dv   <= 1'b1;
        spi.rx_byte <= eng_resp;
        eng_busy    <= 1'b0;
      end else eng_lat <= eng_lat - 1;
    end else if (spi.tx_dv) begin
      log_b.push_back(spi.tx_byte);
      log_cs.push_back(cs);
      card_reply = 8'hFF;
      if (cs) begin
        cmd_buf.delete(); resp_q.delete();
      end else if (resp_q.size() != 0) begin
        card_reply = resp_q.pop_front();
      end else if (cmd_buf.size() != 0 || spi.tx_byte[7:6] == 2'b01) begin
        cmd_buf.push_back(spi.tx_byte);
        if (cmd_buf.size() == 6) begin
          respond(cmd_buf[0][5:0]);
          cmd_buf.delete();
        end
      end
      eng_resp <= card_reply;
      eng_byte <= spi.tx_byte;
      eng_busy <= 1'b1;
      eng_lat  <= int'($urandom_range(0, 3));
    end
  end

  // ---------------- reference model ----------------
  int         exp_q[$];
  logic       exp_done, exp_err, exp_sdhc;
  logic [2:0] exp_code;

  task automatic model();
    exp_q.delete(); exp_q.push_back(0);
    exp_done = 0; exp_err = 0; exp_code = 0; exp_sdhc = 0;
    if (silent) begin exp_err = 1; exp_code = 5; return; end
    exp_q.push_back(8);
    if (echo[11:0] != 12'h1AA) begin exp_err = 1; exp_code = 2; return; end
    for (int p = 1; p <= RETRIES; p++) begin
      exp_q.push_back(55); exp_q.push_back(41);
      if (p > busy_n) begin
        exp_q.push_back(58); exp_done = 1; exp_sdhc = ocr[30]; return;
      end
    end
    exp_err = 1; exp_code = 3;
  endtask

  function automatic logic [31:0] t_arg(input int idx);
    return idx == 8 ? 32'h0000_01AA : idx == 41 ? 32'h4000_0000 : 32'h0;
  endfunction

  function automatic logic [7:0] t_crc(input int idx);
    case (idx)
      0: return 8'h95;  8: return 8'h87;  55: return 8'h65;
      41: return 8'h77; 58: return 8'hFD; default: return 8'h00;
    endcase
  endfunction

  // Split the byte log of one run into CS-low frames and check framing.
  task automatic check_log(input string tag, input int base, input bit to_case);
    int i = base, dummy = 0, bad = 0, gaps_bad = 0, last_seg = 0, trail = 0, n55 = 0, seq_bad = 0;
    int got[$];
    while (i < log_b.size() && log_cs[i]) begin dummy++; i++; end
    while (i < log_b.size()) begin
      int s = i, g;
      while (i < log_b.size() && !log_cs[i]) i++;
      last_seg = i - s;
      if (last_seg < 6 || log_b[s][7:6] != 2'b01) bad++;
      else begin
        int idx = int'(log_b[s][5:0]);
        if ({log_b[s+1], log_b[s+2], log_b[s+3], log_b[s+4]} != t_arg(idx) ||
            log_b[s+5] != t_crc(idx)) bad++;
        got.push_back(idx);
        if (idx == 55) n55++;
      end
      g = i;
      while (i < log_b.size() && log_cs[i]) i++;
      trail = i - g;
      if (i < log_b.size() && trail != 1) gaps_bad++;
    end
    chk({tag, "_dummy_bytes"}, dummy, 10);
    chk({tag, "_frame_count"}, got.size(), exp_q.size());
    for (int k = 0; k < got.size() && k < exp_q.size(); k++)
      if (got[k] != exp_q[k]) seq_bad++;
    chk({tag, "_cmd_order_errs"}, seq_bad, 0);
    chk({tag, "_frame_bytes_errs"}, bad, 0);
    chk({tag, "_gap_errs"}, gaps_bad, 0);
    chk({tag, "_trailing_cs_high"}, trail, to_case ? 0 : 1);
    if (to_case) chk({tag, "_timeout_seg_len"}, last_seg, 14);
    if (exp_q.size() == 2) chk({tag, "_cmd55_count"}, n55, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, err, 0);
    chk({tag, "_code"}, code, 0);
    chk({tag, "_sdhc"}, sdhc, 0);
    chk({tag, "_cs"}, cs, 1);
    chk({tag, "_tx_dv"}, spi.tx_dv, 0);
    chk({tag, "_tx_byte"}, spi.tx_byte, 8'hFF);
  endtask

  task automatic run_case(input string tag, input bit to_case, input bit poke);
    int base, n = 0;
    repeat (8) @(negedge clk);
    base = log_b.size();
    model();
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    if (poke) begin
      repeat ($urandom_range(40, 120)) @(negedge clk);
      chk({tag, "_busy_at_restart"}, busy, 1);
      start = 1'b1; @(negedge clk); start = 1'b0;
    end
    while (busy && n < 20000) begin @(negedge clk); n++; end
    chk({tag, "_finished_in_budget"}, n < 20000, 1);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, err, exp_err);
    chk({tag, "_code"}, code, exp_code);
    chk({tag, "_sdhc"}, sdhc, exp_sdhc);
    chk({tag, "_cs_high"}, cs, 1);
    chk({tag, "_protocol_viol"}, viol, 0);
    check_log(tag, base, to_case);
  endtask

  initial begin
    int n;
    silent = 0; echo = 32'h0000_01AA; busy_n = 2; ocr = 32'hC0FF_8000;
    #1;
    check_reset_vals("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_case("sdhc", 0, 1);
    ocr = 32'h80FF_8000;
    run_case("sdsc", 0, 0);
    silent = 1;
    run_case("r1_timeout", 1, 0);
    silent = 0; echo = 32'h0000_01AB;
    run_case("cmd8_echo", 0, 0);
    echo = 32'h0000_01AA; busy_n = 1000;
    run_case("acmd41_exhaust", 0, 0);

    // Reset while CMD8 argument byte 3 (0x01) is in flight.
    busy_n = 0; ocr = 32'hC000_0000;
    repeat (8) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(spi.tx_dv && !cs && spi.tx_byte == 8'h01) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("cmd8_byte3_seen", n < 5000, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    run_case("after_reset", 0, 0);

    for (int r = 0; r < 3; r++) begin
      busy_n = int'($urandom_range(0, 5));
      ocr    = $urandom;
      echo   = ($urandom_range(0, 3) == 0) ? {$urandom} : 32'h0000_01AA;
      run_case($sformatf("rand%0d", r), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
